// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared types and constants for the multi-cycle sequencer (states, opcodes, functs, ALU codes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // Instruction classes seen by the FSM; every legal opcode/funct maps to one.
    typedef enum logic [2:0] {
        CLS_RALU = 3'd0,
        CLS_ADDI = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4,
        CLS_J    = 3'd5,
        CLS_ILL  = 3'd6
    } iclass_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose: bundles the sequencer <-> datapath signals (yIF/yID/yEX inputs, control outputs).
// Latency: n/a (wiring only).
// Backpressure: none; run is the only throttle and is sampled in FETCH.
// master = sequencer (drives pc and controls), slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int COUNT_W = 16
) ();
    logic               run;
    logic [31:0]        ins;
    logic               zero;
    logic [31:0]        pc_plus4;
    logic [31:0]        imm;
    logic [25:0]        j_target;
    logic [31:0]        pc;
    logic               ir_load;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src;
    logic [2:0]         alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic [2:0]         state;
    logic [COUNT_W-1:0] instr_count;
    logic               illegal;

    modport master (
        input  run, ins, zero, pc_plus4, imm, j_target,
        output pc, ir_load, reg_dst, reg_write, alu_src, alu_op,
               mem_read, mem_write, mem_to_reg, state, instr_count, illegal
    );

    modport slave (
        output run, ins, zero, pc_plus4, imm, j_target,
        input  pc, ir_load, reg_dst, reg_write, alu_src, alu_op,
               mem_read, mem_write, mem_to_reg, state, instr_count, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Purpose: combinational opcode/funct decode into instruction class, ALU op and illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op/funct in (ins[31:26]/ins[5:0]); cls, alu_op, illegal out.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        cls    = CLS_ILL;
        alu_op = ALU_ADD;
        unique case (op)
            OP_R: begin
                unique case (funct)
                    FN_ADD:  begin cls = CLS_RALU; alu_op = ALU_ADD; end
                    FN_AND:  begin cls = CLS_RALU; alu_op = ALU_AND; end
                    FN_OR:   begin cls = CLS_RALU; alu_op = ALU_OR;  end
                    FN_SLT:  begin cls = CLS_RALU; alu_op = ALU_SLT; end
                    default: cls = CLS_ILL;
                endcase
            end
            OP_ADDI: cls = CLS_ADDI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  begin cls = CLS_BEQ; alu_op = ALU_SUB; end
            OP_J:    cls = CLS_J;
            default: cls = CLS_ILL;
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle sequencer; owns PC, walks F-D-E-M-W per instruction class, drives datapath controls.
// Latency: 2 (j/illegal) to 5 (lw) cycles per instruction; PC and instr_count update on the edge leaving the last state.
// Backpressure: run=0 parks the FSM in FETCH; once past FETCH an instruction always completes, no stalls.
// Ports: clk, reset (async, active-high); bus = multicycle_ctrl_if.master carrying run/ins/zero/pc_plus4/imm/j_target
//        in and pc/ir_load/reg_dst/reg_write/alu_src/alu_op/mem_read/mem_write/mem_to_reg/state/instr_count/illegal out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd128,
    parameter int          COUNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    state_t             state_q;
    state_t             state_d;
    iclass_t            cls;
    logic [2:0]         dec_alu_op;
    logic               dec_illegal;
    logic [31:0]        pc_q;
    logic [31:0]        pc_next;
    logic [COUNT_W-1:0] count_q;
    logic               retire;

    logic               ir_load;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src;
    logic [2:0]         alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               illegal;

    multicycle_ctrl_decode u_decode (
        .op      (bus.ins[31:26]),
        .funct   (bus.ins[5:0]),
        .cls     (cls),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next state: each class exits to FETCH from its last state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  state_d = bus.run ? DECODE : FETCH;
            DECODE: state_d = (cls == CLS_J || cls == CLS_ILL) ? FETCH : EXEC;
            EXEC: begin
                if (cls == CLS_BEQ)                       state_d = FETCH;
                else if (cls == CLS_LW || cls == CLS_SW) state_d = MEM;
                else                                      state_d = WB;
            end
            MEM:    state_d = (cls == CLS_LW) ? WB : FETCH;
            WB:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Control outputs: each enable is qualified by the state it belongs to
    always_comb begin
        ir_load    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            FETCH:  ir_load = 1'b1;
            // Illegal instructions retire out of DECODE, so the pulse is exactly this cycle.
            DECODE: illegal = dec_illegal;
            EXEC, MEM, WB: begin
                alu_src = (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
                alu_op  = dec_alu_op;
                if (state_q == MEM) begin
                    mem_read  = (cls == CLS_LW);
                    mem_write = (cls == CLS_SW);
                end
                if (state_q == WB) begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls == CLS_RALU);
                    mem_to_reg = (cls == CLS_LW);
                end
            end
            default: ir_load = 1'b0;
        endcase
    end

    // An instruction retires on any transition back into FETCH from a working state.
    assign retire = (state_q != FETCH) && (state_d == FETCH);

    always_comb begin
        pc_next = bus.pc_plus4;
        if (cls == CLS_BEQ && bus.zero)
            pc_next = bus.pc_plus4 + {bus.imm[29:0], 2'b00};
        else if (cls == CLS_J)
            pc_next = {bus.pc_plus4[31:28], bus.j_target, 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else if (retire) begin
            pc_q    <= pc_next;
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.instr_count = count_q;
    assign bus.state       = state_q;
    assign bus.ir_load     = ir_load;
    assign bus.reg_dst     = reg_dst;
    assign bus.reg_write   = reg_write;
    assign bus.alu_src     = alu_src;
    assign bus.alu_op      = alu_op;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.illegal     = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: directed-vector scoreboard bench for multicycle_ctrl; expected per-cycle outputs are queued by stimulus.
// Latency: n/a.
// Backpressure: n/a; the bench plays the yIF/yID/yEX side and drives run.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.COUNT_W(16)) bus ();

    multicycle_ctrl #(
        .RESET_PC (32'd128),
        .COUNT_W  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // yIF adder
    assign bus.pc_plus4 = bus.pc + 32'd4;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;

    // {ir_load, reg_dst, reg_write, alu_src}_{alu_op}_{mem_read, mem_write, mem_to_reg, illegal}
    localparam logic [10:0] C_F      = 11'b1000_000_0000;
    localparam logic [10:0] C_0      = 11'b0000_000_0000;
    localparam logic [10:0] C_EX_R   = 11'b0000_010_0000;
    localparam logic [10:0] C_WB_R   = 11'b0110_010_0000;
    localparam logic [10:0] C_EX_I   = 11'b0001_010_0000;
    localparam logic [10:0] C_MEM_LW = 11'b0001_010_1000;
    localparam logic [10:0] C_WB_LW  = 11'b0011_010_0010;
    localparam logic [10:0] C_MEM_SW = 11'b0001_010_0100;
    localparam logic [10:0] C_EX_BEQ = 11'b0000_110_0000;
    localparam logic [10:0] C_ILL    = 11'b0000_000_0001;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [10:0] ctl;
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [10:0] ctl_now();
        return {bus.ir_load, bus.reg_dst, bus.reg_write, bus.alu_src, bus.alu_op,
                bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.illegal};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic ex(input string nm, input logic [2:0] st, input logic [10:0] ctl,
                      input logic [31:0] pc, input logic [15:0] cnt);
        exp_t e;
        e.name = nm; e.st = st; e.ctl = ctl; e.pc = pc; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] i, input logic z, input logic [31:0] im, input logic [25:0] jt);
        bus.ins      = i;
        bus.zero     = z;
        bus.imm      = im;
        bus.j_target = jt;
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".state"}, 32'(bus.state), 32'(e.st));
            check({e.name, ".ctl"},   32'(ctl_now()), 32'(e.ctl));
            check({e.name, ".pc"},    bus.pc,         e.pc);
            check({e.name, ".count"}, 32'(bus.instr_count), 32'(e.cnt));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        bus.run = 1'b0;
        issue(32'h0, 1'b0, 32'h0, 26'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ex("reset", S_F, C_F, 32'd128, 16'd0);
        step(1);

        // add $3,$1,$2; run dropped after FETCH must not disturb it
        bus.run = 1'b1;
        issue(32'h00221820, 1'b0, 32'h0, 26'h0);
        ex("add.F", S_F, C_F,    32'd128, 16'd0);
        ex("add.D", S_D, C_0,    32'd128, 16'd0);
        ex("add.E", S_E, C_EX_R, 32'd128, 16'd0);
        ex("add.W", S_W, C_WB_R, 32'd128, 16'd0);
        step(1);
        bus.run = 1'b0;
        step(3);
        bus.run = 1'b1;

        issue(32'h8C220004, 1'b0, 32'd4, 26'h0);
        ex("lw.F", S_F, C_F,      32'd132, 16'd1);
        ex("lw.D", S_D, C_0,      32'd132, 16'd1);
        ex("lw.E", S_E, C_EX_I,   32'd132, 16'd1);
        ex("lw.M", S_M, C_MEM_LW, 32'd132, 16'd1);
        ex("lw.W", S_W, C_WB_LW,  32'd132, 16'd1);
        step(5);

        issue(32'hAC220004, 1'b0, 32'd4, 26'h0);
        ex("sw.F", S_F, C_F,      32'd136, 16'd2);
        ex("sw.D", S_D, C_0,      32'd136, 16'd2);
        ex("sw.E", S_E, C_EX_I,   32'd136, 16'd2);
        ex("sw.M", S_M, C_MEM_SW, 32'd136, 16'd2);
        step(4);

        // beq not taken: 140 -> 144
        issue(32'h10220003, 1'b0, 32'd3, 26'h0);
        ex("beq_nt.F", S_F, C_F,      32'd140, 16'd3);
        ex("beq_nt.D", S_D, C_0,      32'd140, 16'd3);
        ex("beq_nt.E", S_E, C_EX_BEQ, 32'd140, 16'd3);
        step(3);

        // beq taken backwards (imm=-2, 32-bit wrap): 148 - 8 = 140
        issue(32'h1022FFFE, 1'b1, 32'hFFFF_FFFE, 26'h0);
        ex("beq_back.F", S_F, C_F,      32'd144, 16'd4);
        ex("beq_back.D", S_D, C_0,      32'd144, 16'd4);
        ex("beq_back.E", S_E, C_EX_BEQ, 32'd144, 16'd4);
        step(3);

        // beq taken imm=3 at 140: 144 + 12 = 156
        issue(32'h10220003, 1'b1, 32'd3, 26'h0);
        ex("beq_t.F", S_F, C_F,      32'd140, 16'd5);
        ex("beq_t.D", S_D, C_0,      32'd140, 16'd5);
        ex("beq_t.E", S_E, C_EX_BEQ, 32'd140, 16'd5);
        step(3);

        // beq taken imm=10 at 156: 160 + 40 = 200
        issue(32'h1022000A, 1'b1, 32'd10, 26'h0);
        ex("beq_200.F", S_F, C_F,      32'd156, 16'd6);
        ex("beq_200.D", S_D, C_0,      32'd156, 16'd6);
        ex("beq_200.E", S_E, C_EX_BEQ, 32'd156, 16'd6);
        step(3);

        // j 0x20 at 200 -> {0, 0x20, 00} = 128
        issue(32'h08000020, 1'b0, 32'h0, 26'h20);
        ex("j.F", S_F, C_F, 32'd200, 16'd7);
        ex("j.D", S_D, C_0, 32'd200, 16'd7);
        step(2);

        // opcode 0x3F: illegal pulse in DECODE only, pc += 4
        issue(32'hFC000000, 1'b0, 32'h0, 26'h0);
        ex("ill_op.F", S_F, C_F,   32'd128, 16'd8);
        ex("ill_op.D", S_D, C_ILL, 32'd128, 16'd8);
        step(2);

        // R-type with unsupported funct 0x27
        issue(32'h00221827, 1'b0, 32'h0, 26'h0);
        ex("ill_fn.F", S_F, C_F,   32'd132, 16'd9);
        ex("ill_fn.D", S_D, C_ILL, 32'd132, 16'd9);
        step(2);

        // lw interrupted by reset in MEM
        issue(32'h8C220004, 1'b0, 32'd4, 26'h0);
        ex("lw_rst.F", S_F, C_F,    32'd136, 16'd10);
        ex("lw_rst.D", S_D, C_0,    32'd136, 16'd10);
        ex("lw_rst.E", S_E, C_EX_I, 32'd136, 16'd10);
        step(3);
        ex("lw_rst.M", S_M, C_MEM_LW, 32'd136, 16'd10);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        // Mid-cycle, no clock edge since reset rose: only an async reset can pass these
        check("async_rst.state",    32'(bus.state),         32'(S_F));
        check("async_rst.pc",       bus.pc,                 32'd128);
        check("async_rst.mem_read", 32'(bus.mem_read),      32'd0);
        check("async_rst.count",    32'(bus.instr_count),   32'd0);
        check("async_rst.ctl",      32'(ctl_now()),         32'(C_F));
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // run=0: FETCH held, pc stays at entry point
        for (int k = 0; k < 10; k++) ex("hold", S_F, C_F, 32'd128, 16'd0);
        step(10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
